// File: rtl/attack_scheduler.sv
// Attack-list sequencer: walks the stage's ROM entries, keeps game time,
// handshakes fetch/position-sync with the ROM reader and allocates object slots.
module attack_scheduler #(
    parameter int ADDR_WIDTH    = 10,
    parameter int MAXIMUM_TIMES = 30,
    parameter int NUM_SLOTS     = 8,
    parameter int SLOT_W        = 3,
    parameter int TICK_DIV      = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    input  logic [ADDR_WIDTH-1:0]    start_addr,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    output logic                     rom_sync,
    input  logic                     rom_update,
    input  logic [MAXIMUM_TIMES-1:0] rom_next_time,
    input  logic [4:0]               rom_types,
    output logic                     rom_pos_ack,
    input  logic                     rom_pos_sync,
    output logic [MAXIMUM_TIMES-1:0] current_time,
    input  logic [NUM_SLOTS-1:0]     slot_busy,
    output logic                     spawn,
    output logic [SLOT_W-1:0]        spawn_slot,
    output logic                     busy,
    output logic                     done
);

    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ALLOC, S_SPAWN, S_ACK, S_WAIT_TIME, S_DONE
    } state_t;

    state_t                   state, state_next;
    logic [TICK_W-1:0]        tick, tick_next;
    logic [MAXIMUM_TIMES-1:0] sched_time, sched_time_next;
    logic [MAXIMUM_TIMES-1:0] current_time_next;
    logic [ADDR_WIDTH-1:0]    rom_addr_next;
    logic                     rom_sync_next, rom_pos_ack_next, spawn_next;
    logic [SLOT_W-1:0]        spawn_slot_next;
    logic                     busy_next, done_next;
    logic                     free_found;
    logic [SLOT_W-1:0]        free_idx;
    logic                     running;

    // Lowest-index free slot wins: scan downward so the last hit is the lowest.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    assign running = (state != S_IDLE) && (state != S_DONE) && !pause;

    always_comb begin
        state_next        = state;
        tick_next         = tick;
        current_time_next = current_time;
        sched_time_next   = sched_time;
        rom_addr_next     = rom_addr;
        rom_sync_next     = rom_sync;
        rom_pos_ack_next  = rom_pos_ack;
        spawn_next        = spawn;
        spawn_slot_next   = spawn_slot;

        if (running) begin
            if (tick == TICK_W'(TICK_DIV - 1)) begin
                tick_next = '0;
                if (~&current_time)
                    current_time_next = current_time + MAXIMUM_TIMES'(1);
            end else begin
                tick_next = tick + TICK_W'(1);
            end
        end

        if (!pause) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rom_addr_next     = start_addr;
                        current_time_next = '0;
                        tick_next         = '0;
                        rom_sync_next     = 1'b0;
                        state_next        = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (rom_update) begin
                        sched_time_next = rom_next_time;
                        rom_sync_next   = 1'b1;
                        state_next      = (rom_types == 5'd0) ? S_DONE : S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (free_found) begin
                        spawn_slot_next = free_idx;
                        spawn_next      = 1'b1;
                        state_next      = S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    spawn_next       = 1'b0;
                    rom_pos_ack_next = 1'b1;
                    state_next       = S_ACK;
                end
                S_ACK: begin
                    if (rom_pos_sync) begin
                        rom_pos_ack_next = 1'b0;
                        state_next       = S_WAIT_TIME;
                    end
                end
                S_WAIT_TIME: begin
                    // Compare against the pre-increment time; the last ROM word ends the stage.
                    if (current_time >= sched_time) begin
                        if (&rom_addr) begin
                            state_next = S_DONE;
                        end else begin
                            rom_addr_next = rom_addr + ADDR_WIDTH'(1);
                            rom_sync_next = 1'b0;
                            state_next    = S_FETCH;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end

        busy_next = (state_next != S_IDLE) && (state_next != S_DONE);
        done_next = (state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            tick         <= '0;
            current_time <= '0;
            sched_time   <= '0;
            rom_addr     <= '0;
            rom_sync     <= 1'b1;
            rom_pos_ack  <= 1'b0;
            spawn        <= 1'b0;
            spawn_slot   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            tick         <= tick_next;
            current_time <= current_time_next;
            sched_time   <= sched_time_next;
            rom_addr     <= rom_addr_next;
            rom_sync     <= rom_sync_next;
            rom_pos_ack  <= rom_pos_ack_next;
            spawn        <= spawn_next;
            spawn_slot   <= spawn_slot_next;
            busy         <= busy_next;
            done         <= done_next;
        end
    end

endmodule

// File: tb/tb_attack_scheduler.sv
// Bench for attack_scheduler: directed stage runs against a phase/arithmetic
// reference model compared every cycle, plus hand-computed literal checks.
module tb_attack_scheduler;

    localparam int AW   = 10;
    localparam int TW   = 30;
    localparam int NS   = 8;
    localparam int SW   = 3;
    localparam int TDIV = 4;
    localparam longint TMAX = (64'd1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, pause;
    logic [AW-1:0] start_addr, rom_addr;
    logic          rom_sync, rom_update, rom_pos_ack, rom_pos_sync;
    logic [TW-1:0] rom_next_time, current_time;
    logic [4:0]    rom_types;
    logic [NS-1:0] slot_busy;
    logic          spawn, busy, done;
    logic [SW-1:0] spawn_slot;

    int n_checks = 0;
    int n_err    = 0;
    int spawn_cnt = 0;
    int pos_delay = 0;
    bit check_en = 1'b0;

    attack_scheduler #(
        .ADDR_WIDTH(AW), .MAXIMUM_TIMES(TW), .NUM_SLOTS(NS), .SLOT_W(SW), .TICK_DIV(TDIV)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .start_addr(start_addr),
        .rom_addr(rom_addr), .rom_sync(rom_sync), .rom_update(rom_update),
        .rom_next_time(rom_next_time), .rom_types(rom_types), .rom_pos_ack(rom_pos_ack),
        .rom_pos_sync(rom_pos_sync), .current_time(current_time), .slot_busy(slot_busy),
        .spawn(spawn), .spawn_slot(spawn_slot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ROM reader responder: 2-cycle fetch, configurable position-sync delay.
    int f_cnt = 0;
    int p_cnt = 0;
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            f_cnt = 0; p_cnt = 0; rom_update = 1'b0; rom_pos_sync = 1'b0;
        end else begin
            if (rom_sync) begin
                f_cnt = 0; rom_update = 1'b0;
            end else begin
                f_cnt++;
                if (f_cnt >= 2) rom_update = 1'b1;
            end
            if (rom_pos_ack) begin
                if (p_cnt >= pos_delay) rom_pos_sync = 1'b1;
                p_cnt++;
            end else begin
                p_cnt = 0; rom_pos_sync = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset && spawn) begin
            spawn_cnt++;
            $display("spawn slot=%0d addr=%0d time=%0d", spawn_slot, rom_addr, current_time);
        end
    end

    // Reference model: stage phase plus game time derived from active cycle count.
    localparam int P_IDLE = 0, P_FETCH = 1, P_ALLOC = 2, P_SPAWN = 3, P_ACK = 4, P_WAIT = 5, P_DONE = 6;
    int            m_phase;
    longint        m_active, m_sched;
    logic [AW-1:0] m_addr;
    int            m_slot;

    function automatic longint m_now(input longint act);
        return (act / TDIV > TMAX) ? TMAX : act / TDIV;
    endfunction

    always @(posedge clk or negedge reset) begin : model
        int k;
        bit was_running;
        longint now;
        if (!reset) begin
            m_phase = P_IDLE; m_active = 0; m_addr = '0; m_sched = 0; m_slot = 0;
        end else if (!pause) begin
            now = m_now(m_active);
            was_running = (m_phase != P_IDLE) && (m_phase != P_DONE);
            case (m_phase)
                P_IDLE, P_DONE:
                    if (start) begin m_addr = start_addr; m_active = 0; m_phase = P_FETCH; end
                P_FETCH:
                    if (rom_update) begin
                        m_sched = longint'(rom_next_time);
                        m_phase = (rom_types == 0) ? P_DONE : P_ALLOC;
                    end
                P_ALLOC: begin
                    k = 0;
                    while (k < NS && slot_busy[k]) k++;
                    if (k < NS) begin m_slot = k; m_phase = P_SPAWN; end
                end
                P_SPAWN: m_phase = P_ACK;
                P_ACK:   if (rom_pos_sync) m_phase = P_WAIT;
                default:
                    if (now >= m_sched) begin
                        if (m_addr == AW'((1 << AW) - 1)) m_phase = P_DONE;
                        else begin m_addr = m_addr + 1'b1; m_phase = P_FETCH; end
                    end
            endcase
            if (was_running) m_active++;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_rom_addr", rom_addr, m_addr);
            chk("cyc_rom_sync", rom_sync, m_phase != P_FETCH);
            chk("cyc_pos_ack", rom_pos_ack, m_phase == P_ACK);
            chk("cyc_spawn", spawn, m_phase == P_SPAWN);
            chk("cyc_spawn_slot", spawn_slot, m_slot);
            chk("cyc_time", current_time, m_now(m_active));
            chk("cyc_busy", busy, (m_phase != P_IDLE) && (m_phase != P_DONE));
            chk("cyc_done", done, m_phase == P_DONE);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [AW-1:0] a);
        @(negedge clk);
        start_addr = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        longint t0, a0;
        reset = 1'b0; start = 1'b0; pause = 1'b0; start_addr = '0;
        rom_next_time = '0; rom_types = '0; slot_busy = '0;
        cyc(3);
        reset = 1'b1;
        check_en = 1'b1;
        cyc(1);
        chk("reset_sync", rom_sync, 1);
        chk("reset_addr", rom_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_time", current_time, 0);

        // Stage at 5: types=3, time 4, slots 0/1 busy.
        rom_types = 5'd3; rom_next_time = 30'd4; slot_busy = 8'b0000_0011; pos_delay = 3;
        pulse_start(10'd5);
        chk("start_addr", rom_addr, 5);
        chk("start_sync", rom_sync, 0);
        chk("start_time", current_time, 0);
        n = 0; while (!spawn && n < 100) begin cyc(1); n++; end
        chk("spawn_wait_ok", n < 100, 1);
        chk("first_slot", spawn_slot, 2);
        cyc(1);
        chk("spawn_one_cycle", spawn, 0);
        chk("ack_held", rom_pos_ack, 1);
        cyc(1);
        chk("ack_still_held", rom_pos_ack, 1);
        n = 0; while (rom_addr != 10'd6 && n < 200) begin cyc(1); n++; end
        chk("advance_wait_ok", n < 200, 1);
        chk("advance_time", current_time, 4);

        // Entry 6: all slots busy for ~50 cycles, stray start ignored.
        rom_next_time = 30'd40; slot_busy = 8'hFF;
        n = 0; while (!rom_sync && n < 20) begin cyc(1); n++; end
        chk("fetch6_wait_ok", n < 20, 1);
        s0 = spawn_cnt;
        cyc(20);
        pulse_start(10'd100);
        cyc(28);
        chk("stall_no_spawn", spawn_cnt, s0);
        chk("start_ignored", rom_addr, 6);
        slot_busy = 8'hBF;
        n = 0; while (!spawn && n < 10) begin cyc(1); n++; end
        chk("stall_spawn_ok", n < 10, 1);
        chk("stall_slot", spawn_slot, 6);
        cyc(1);
        n = 0; while (rom_pos_ack && n < 20) begin cyc(1); n++; end
        chk("ack_release_ok", n < 20, 1);
        cyc(2);

        // Pause in WAIT_TIME for 3 game-time units.
        t0 = current_time; a0 = rom_addr;
        pause = 1'b1;
        cyc(3 * TDIV);
        chk("pause_time", current_time, t0);
        chk("pause_addr", rom_addr, a0);
        chk("pause_busy", busy, 1);
        pause = 1'b0;

        rom_types = 5'd0;
        n = 0; while (!done && n < 400) begin cyc(1); n++; end
        chk("done_wait_ok", n < 400, 1);
        chk("done_busy", busy, 0);
        chk("done_addr", rom_addr, 7);
        chk("spawn_total", spawn_cnt, 2);

        // Restart from DONE at address 0.
        pulse_start(10'd0);
        chk("restart_time", current_time, 0);
        chk("restart_addr", rom_addr, 0);
        chk("restart_sync", rom_sync, 0);
        n = 0; while (!done && n < 50) begin cyc(1); n++; end
        chk("restart_done_ok", n < 50, 1);
        chk("restart_no_spawn", spawn_cnt, 2);

        // Last ROM word must end the stage instead of wrapping.
        rom_types = 5'd3; rom_next_time = 30'd0; slot_busy = 8'h00;
        pulse_start(10'd1023);
        n = 0; while (!done && n < 100) begin cyc(1); n++; end
        chk("top_done_ok", n < 100, 1);
        chk("top_addr", rom_addr, 1023);
        chk("top_spawns", spawn_cnt, 3);
        chk("top_slot", spawn_slot, 0);

        // Asynchronous reset mid-FETCH.
        pulse_start(10'd5);
        #2 reset = 1'b0;
        #1;
        chk("async_sync", rom_sync, 1);
        chk("async_addr", rom_addr, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_time", current_time, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/attack_scheduler.md
# attack_scheduler

Sequences the attack-object ROM reader through a stage's attack list. It owns the ROM address pointer and the game time base. It handshakes each entry fetch and position-sync with the reader, and allocates a free object slot for every attack spawned. It sits between the stage/game-runtime control and the ROM reader plus the object-slot array.

## Interface
Parameters:
- ADDR_WIDTH, 10, ROM address width; must match the ROM reader.
- MAXIMUM_TIMES, 30, width of game time and scheduled time.
- NUM_SLOTS, 8, number of object slots arbitrated.
- SLOT_W, 3, width of slot index (clog2 NUM_SLOTS).
- TICK_DIV, 100000, clk cycles per game-time unit (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- start  input  1  single-cycle pulse; starts a stage at start_addr.
- pause  input  1  freezes the time base and FSM while high.
- start_addr  input  ADDR_WIDTH  first ROM entry of the stage.
- rom_addr  output  ADDR_WIDTH  entry address to the ROM reader.
- rom_sync  output  1  drives reader sync_attack_time; 0 = fetch request, 1 = acknowledge/idle.
- rom_update  input  1  reader update_attack_time; entry fields and next time valid.
- rom_next_time  input  MAXIMUM_TIMES  reader next_attack_time.
- rom_types  input  5  reader types; 0 marks end of stage.
- rom_pos_ack  output  1  drives reader update_attack_position.
- rom_pos_sync  input  1  reader sync_attack_position.
- current_time  output  MAXIMUM_TIMES  game time, fed back to the reader.
- slot_busy  input  NUM_SLOTS  bit i = 1 when slot i holds a live object.
- spawn  output  1  single-cycle pulse; load current entry into spawn_slot.
- spawn_slot  output  SLOT_W  slot chosen for spawn.
- busy  output  1  high in any state other than IDLE/DONE.
- done  output  1  high in DONE.

## Operation
- States: IDLE, FETCH, ALLOC, SPAWN, ACK, WAIT_TIME, DONE.
- IDLE:
  - rom_sync=1.
  - On start: rom_addr←start_addr, current_time←0, tick counter←0, then go to FETCH.
- FETCH:
  - rom_sync=0.
  - On rom_update=1: latch sched_time←rom_next_time, set rom_sync←1.
  - If rom_types==0, go to DONE; else go to ALLOC.
- ALLOC:
  - If any slot_busy bit is 0, pick the lowest-index free slot into spawn_slot and go to SPAWN.
  - If all slots are busy, stay in ALLOC (stall); time keeps running.
- SPAWN:
  - spawn=1 for exactly one cycle.
  - Set rom_pos_ack←1 and go to ACK.
- ACK:
  - Hold rom_pos_ack=1 until rom_pos_sync sampled 1, then clear rom_pos_ack and go to WAIT_TIME.
- WAIT_TIME:
  - When current_time ≥ sched_time: if rom_addr is all ones, go to DONE (no wrap); else rom_addr←rom_addr+1 and go to FETCH.
- DONE:
  - done=1, rom_sync=1.
  - start restarts exactly as from IDLE.
- start in any other state: ignored.
- Time base:
  - The tick counter counts 0..TICK_DIV-1; on wrap, current_time increments.
  - current_time saturates at all ones.
  - It runs only in FETCH..WAIT_TIME with pause=0.
- pause=1:
  - No state transitions, no spawn pulse, no latching.
  - Tick counter holds; all outputs hold their values.
- sched_time comparison is unsigned, full MAXIMUM_TIMES width.

## Timing
- Reset values: rom_addr=0, rom_sync=1, rom_pos_ack=0, spawn=0, spawn_slot=0, current_time=0, busy=0, done=0, state IDLE, sched_time=0, tick counter=0.
- All outputs are registered; state changes on the edge where the condition is sampled true.
- start sampled at edge N → FETCH and rom_sync=0 from N+1.
- rom_update sampled → rom_sync=1 on the next cycle.
  - With the reader's 2-cycle fetch, FETCH lasts ≥3 cycles.
- ALLOC with a free slot → spawn asserted the following cycle.
  - slot_busy is sampled in ALLOC only.
  - A slot freed during the stall is taken on the cycle after it reads 0.
- rom_pos_sync high on entry to ACK → ACK lasts 1 cycle.
- Simultaneous tick wrap and WAIT_TIME compare use the pre-increment current_time.
- pause asserted the same cycle as a transition condition: pause wins.
- Reset asserted mid-stage: immediate return to reset values, including rom_sync=1, which releases the reader.

## Test plan
- Reset then start with start_addr=5: rom_addr=5, rom_sync falls 1 cycle later, current_time=0.
- Reader model returns types=3, next_time=4, slot_busy=8'b0000_0011:
  - spawn pulses once with spawn_slot=2.
  - rom_pos_ack is held until rom_pos_sync=1.
  - rom_addr becomes 6 exactly when current_time reaches 4.
- All slots busy in ALLOC for 50 cycles, then slot_busy[6]=0: no spawn during the stall, then spawn with spawn_slot=6.
- Entry with types=0: done=1, busy=0, no spawn; a later start at start_addr=0 restarts with current_time=0.
- pause held 3·TICK_DIV cycles during WAIT_TIME: current_time unchanged, no transitions; resumes exactly where it stopped after pause drops.
- rom_addr=1023 after spawn: DONE, not wrap to 0. Reset pulse low mid-FETCH: all outputs at reset values asynchronously.
